// File: rtl/pwm_motor_pkg.sv
// Shared constants and the saturating ramp step used by every PWM channel.
// Pure combinational helpers; no state, no backpressure.
package pwm_motor_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
  localparam int   SAT_W   = 32;

  // Moves duty toward tgt by at most step, landing exactly on tgt when closer than one step.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] duty,
                                                input logic [SAT_W-1:0] tgt,
                                                input logic [SAT_W-1:0] step);
    logic [SAT_W:0]   up;
    logic [SAT_W-1:0] res;
    up  = {1'b0, duty} + {1'b0, step};
    res = duty;
    if (duty < tgt) begin
      res = (up >= {1'b0, tgt}) ? tgt : up[SAT_W-1:0];
    end else if (duty > tgt) begin
      res = (step >= (duty - tgt)) ? tgt : (duty - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_motor_ctrl_if.sv
// Command/status bundle between the speed-command registers and the bridge gate drivers.
// Level signals only; no handshake, outputs are continuously valid.
interface pwm_motor_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS*WIDTH-1:0] speed;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       pwm_a;
  logic [CHANNELS-1:0]       pwm_b;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [CHANNELS-1:0]       at_speed;

  modport master (
    output enable, speed, dir,
    input  pwm_a, pwm_b, duty, at_speed
  );

  modport slave (
    input  enable, speed, dir,
    output pwm_a, pwm_b, duty, at_speed
  );
endinterface

// File: rtl/pwm_ramp_channel.sv
// One motor channel: ramps applied duty toward the target, steers PWM onto the active bridge leg.
// Outputs registered (1 cycle after cnt); duty moves only on ramp ticks; no backpressure.
module pwm_ramp_channel
  import pwm_motor_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RAMP_STEP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb,
  input  logic             ramp_tick,
  input  logic [WIDTH-1:0] cnt,
  input  logic             enable,
  input  logic [WIDTH-1:0] speed,
  input  logic             dir,
  output logic             pwm_a,
  output logic             pwm_b,
  output logic [WIDTH-1:0] duty,
  output logic             at_speed
);

  logic [WIDTH-1:0] duty_q, duty_d;
  logic             cur_dir_q, cur_dir_d;
  logic             pwm_a_q, pwm_a_d;
  logic             pwm_b_q, pwm_b_d;
  logic             at_speed_q, at_speed_d;
  logic [WIDTH-1:0] tgt;
  logic             pwm_raw;

  always_comb begin
    // A pending reversal pulls the target to zero so the bridge only flips at rest.
    tgt = (enable && (dir == cur_dir_q)) ? speed : '0;

    duty_d = duty_q;
    if (!enable) begin
      duty_d = '0;
    end else if (ramp_tick) begin
      duty_d = WIDTH'(sat_step(SAT_W'(duty_q), SAT_W'(tgt), SAT_W'(RAMP_STEP)));
    end

    cur_dir_d = cur_dir_q;
    if (pb && (duty_q == '0) && (dir != cur_dir_q)) begin
      cur_dir_d = dir;
    end

    pwm_raw    = enable && (cnt < duty_q);
    pwm_a_d    = pwm_raw && (cur_dir_q == DIR_FWD);
    pwm_b_d    = pwm_raw && (cur_dir_q == DIR_REV);
    at_speed_d = enable && (duty_q == tgt) && (cur_dir_q == dir);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q     <= '0;
      cur_dir_q  <= DIR_FWD;
      pwm_a_q    <= 1'b0;
      pwm_b_q    <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      cur_dir_q  <= cur_dir_d;
      pwm_a_q    <= pwm_a_d;
      pwm_b_q    <= pwm_b_d;
      at_speed_q <= at_speed_d;
    end
  end

  assign pwm_a    = pwm_a_q;
  assign pwm_b    = pwm_b_q;
  assign duty     = duty_q;
  assign at_speed = at_speed_q;

endmodule

// File: rtl/pwm_motor_ctrl.sv
// Multi-channel soft-start PWM H-bridge driver: shared period/ramp counters feeding per-channel rampers.
// PWM outputs lag the shared counter by 1 cycle; reset asserts async, releases after 2 clocks; no backpressure.
module pwm_motor_ctrl
  import pwm_motor_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 2,
  parameter int RAMP_STEP    = 16,
  parameter int RAMP_PERIODS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_motor_ctrl_if.slave bus
);

  localparam int               RC_W     = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RAMP_PERIODS - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic            rst_meta_q, rst_meta_d;
  logic            rst_sync_q, rst_sync_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  ramp_cnt_q, ramp_cnt_d;
  logic             pb;
  logic             ramp_tick;

  logic [CHANNELS-1:0]       pwm_a_w;
  logic [CHANNELS-1:0]       pwm_b_w;
  logic [CHANNELS-1:0]       at_speed_w;
  logic [CHANNELS*WIDTH-1:0] duty_w;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  // The counter stops one short of all-ones so duty == MAX yields a constant-high output.
  always_comb begin
    pb         = (cnt_q == CNT_LAST);
    ramp_tick  = pb && (ramp_cnt_q == RC_LAST);
    cnt_d      = pb ? '0 : cnt_q + 1'b1;
    ramp_cnt_d = ramp_cnt_q;
    if (ramp_tick) begin
      ramp_cnt_d = '0;
    end else if (pb) begin
      ramp_cnt_d = ramp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      cnt_q      <= '0;
      ramp_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_ramp_channel #(
      .WIDTH    (WIDTH),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_sync_q),
      .pb       (pb),
      .ramp_tick(ramp_tick),
      .cnt      (cnt_q),
      .enable   (bus.enable[i]),
      .speed    (bus.speed[i*WIDTH +: WIDTH]),
      .dir      (bus.dir[i]),
      .pwm_a    (pwm_a_w[i]),
      .pwm_b    (pwm_b_w[i]),
      .duty     (duty_w[i*WIDTH +: WIDTH]),
      .at_speed (at_speed_w[i])
    );
  end

  assign bus.pwm_a    = pwm_a_w;
  assign bus.pwm_b    = pwm_b_w;
  assign bus.duty     = duty_w;
  assign bus.at_speed = at_speed_w;

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Bench for pwm_motor_ctrl: directed scenarios plus random commands, scored per cycle
// against a cycle-count based reference model through an expected-value queue.
module tb_pwm_motor_ctrl;

  localparam int W    = 4;
  localparam int CH   = 2;
  localparam int STEP = 4;
  localparam int RP   = 1;
  localparam int MAX  = (1 << W) - 1;

  typedef struct {
    logic [CH-1:0]   pa;
    logic [CH-1:0]   pb;
    logic [CH*W-1:0] du;
    logic [CH-1:0]   as;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  pwm_motor_ctrl_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pwm_motor_ctrl #(
    .WIDTH       (W),
    .CHANNELS    (CH),
    .RAMP_STEP   (STEP),
    .RAMP_PERIODS(RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: time since reset release gives the PWM phase directly.
  int m_sync;
  int m_cyc;
  int m_duty[CH];
  bit m_dir[CH];
  exp_t m_out;

  task automatic model_reset();
    m_sync = 0;
    m_cyc  = 0;
    for (int c = 0; c < CH; c++) begin
      m_duty[c] = 0;
      m_dir[c]  = 1'b0;
    end
    m_out.pa = '0;
    m_out.pb = '0;
    m_out.du = '0;
    m_out.as = '0;
  endtask

  task automatic model_step();
    int  phase;
    bit  period_end;
    bit  tick;
    int  tgt;
    int  nd;
    bit  en;
    bit  d;
    int  spd;
    if (!rst_n) begin
      model_reset();
    end else if (m_sync < 2) begin
      m_sync++;
    end else begin
      phase      = m_cyc % MAX;
      period_end = (phase == MAX - 1);
      tick       = period_end && (((m_cyc / MAX) % RP) == RP - 1);
      for (int c = 0; c < CH; c++) begin
        en  = bus.enable[c];
        d   = bus.dir[c];
        spd = int'(bus.speed[c*W +: W]);
        tgt = (en && d == m_dir[c]) ? spd : 0;
        nd  = m_duty[c];
        if (!en) nd = 0;
        else if (tick) begin
          if (nd < tgt)      nd = (nd + STEP > tgt) ? tgt : nd + STEP;
          else if (nd > tgt) nd = (nd - STEP < tgt) ? tgt : nd - STEP;
        end
        m_out.pa[c] = en && (phase < m_duty[c]) && !m_dir[c];
        m_out.pb[c] = en && (phase < m_duty[c]) && m_dir[c];
        m_out.as[c] = en && (m_duty[c] == tgt) && (m_dir[c] == d);
        if (period_end && m_duty[c] == 0 && d != m_dir[c]) m_dir[c] = d;
        m_duty[c] = nd;
        m_out.du[c*W +: W] = W'(nd);
      end
      m_cyc++;
    end
    exp_q.push_back(m_out);
  endtask

  // Called at a negedge (or time 0): predicts the next n posedges with the current inputs.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic set_ch(input int c, input bit en, input int spd, input bit d);
    bus.enable[c]        = en;
    bus.speed[c*W +: W]  = W'(spd);
    bus.dir[c]           = d;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.pwm_a !== e.pa || bus.pwm_b !== e.pb || bus.duty !== e.du ||
            bus.at_speed !== e.as || (bus.pwm_a & bus.pwm_b) !== '0) begin
          miscompares++;
          $display("FAIL cycle_out t=%0t got pwm_a=%b pwm_b=%b duty=%h at_speed=%b want pwm_a=%b pwm_b=%b duty=%h at_speed=%b",
                   $time, bus.pwm_a, bus.pwm_b, bus.duty, bus.at_speed, e.pa, e.pb, e.du, e.as);
        end
      end
    end
  end

  initial begin : driver
    rst_n      = 1'b0;
    bus.enable = '0;
    bus.speed  = '0;
    bus.dir    = '0;
    model_reset();
    step(3);
    rst_n = 1'b1;
    step(40);

    // Soft-start, full duty, ramp to zero.
    set_ch(0, 1, 12, 0); step(60);
    set_ch(0, 1, 15, 0); step(40);
    set_ch(0, 1, 0, 0);  step(90);

    // Reversal through zero, then a cancelled reversal.
    set_ch(0, 1, 12, 0); step(60);
    set_ch(0, 1, 12, 1); step(120);
    set_ch(0, 1, 12, 0); step(20);
    set_ch(0, 1, 12, 1); step(20);
    set_ch(0, 1, 12, 0); step(60);

    // Enable drop, re-enable, short low pulse.
    set_ch(0, 0, 12, 0); step(5);
    set_ch(0, 1, 12, 0); step(40);
    set_ch(0, 0, 12, 0); step(2);
    set_ch(0, 1, 12, 0); step(60);

    // Independence: ch1 reverses while ch0 holds.
    set_ch(0, 1, 8, 0); set_ch(1, 1, 14, 1); step(120);
    set_ch(1, 1, 14, 0); step(150);

    // Asynchronous reset mid-run with duty at 12.
    set_ch(0, 1, 12, 0); step(60);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.pwm_a !== '0 || bus.pwm_b !== '0 || bus.duty !== '0 || bus.at_speed !== '0) begin
      miscompares++;
      $display("FAIL async_reset got pwm_a=%b pwm_b=%b duty=%h at_speed=%b want all zero",
               bus.pwm_a, bus.pwm_b, bus.duty, bus.at_speed);
    end
    step(3);
    rst_n = 1'b1;
    step(60);

    // Random commands with varied hold times.
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < CH; c++) begin
        set_ch(c, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, MAX)), 1'($urandom_range(0, 1)));
      end
      step(int'($urandom_range(1, 50)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_motor_ctrl.md
Name: pwm_motor_ctrl

Overview:
Multi-channel PWM motor driver with soft-start/soft-stop ramping and H-bridge direction control. It is the parametrised successor to the single-channel speed-to-PWM motor controller. One shared free-running PWM counter serves CHANNELS independent channels. Each channel ramps its applied duty toward a requested speed and reverses direction only through zero duty. It sits between the speed-command registers and the bridge gate drivers.

Parameters:
WIDTH, 8, bit width of speed/duty; PWM period = 2^WIDTH-1 cycles
CHANNELS, 2, number of independent motor channels
RAMP_STEP, 16, duty increment/decrement applied per ramp tick (1..2^WIDTH-1)
RAMP_PERIODS, 4, PWM periods between ramp ticks (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  CHANNELS  per-channel enable; bit i = channel i
speed  in  CHANNELS*WIDTH  target duty per channel, channel i at [i*WIDTH +: WIDTH]
dir  in  CHANNELS  requested direction; 0 = forward, 1 = reverse
pwm_a  out  CHANNELS  forward bridge leg drive (registered)
pwm_b  out  CHANNELS  reverse bridge leg drive (registered)
duty  out  CHANNELS*WIDTH  currently applied duty per channel
at_speed  out  CHANNELS  applied duty == effective target and direction == requested direction

Behaviour:
- Reset (rst_n low, async): cnt=0, ramp_cnt=0, all duty=0, cur_dir=0, pwm_a=pwm_b=0, at_speed=0. The release is synchronised internally by a 2-flop reset release. Mid-operation reset forces outputs low immediately.
- MAX = 2^WIDTH-1. The shared counter cnt counts 0..MAX-1 and wraps to 0. A period boundary (pb) is the cycle in which cnt==MAX-1.
- ramp_cnt counts pb events from 0 to RAMP_PERIODS-1. ramp_tick = pb && ramp_cnt==RAMP_PERIODS-1. ramp_cnt wraps on ramp_tick.
- Raw PWM: pwm_i = (cnt < duty_i). duty=0 gives constant low. duty=MAX gives constant high. Outputs are registered, so they lag cnt by 1 cycle.
- Direction steering: pwm_a = pwm & ~cur_dir, pwm_b = pwm & cur_dir. pwm_a and pwm_b are never both high, in any cycle.
- Effective target tgt_i:
  - 0 if enable_i=0;
  - 0 if dir_i != cur_dir_i (reversal in progress);
  - otherwise speed_i.
- Duty update happens only on ramp_tick, so there are no mid-period glitches:
  - if duty < tgt: duty = min(duty+RAMP_STEP, tgt);
  - if duty > tgt: duty = max(duty-RAMP_STEP, tgt).
  - Arithmetic uses WIDTH+1 bits, so there is no wrap-around past 0 or MAX.
  - speed above MAX is not possible, since speed==MAX is 100%.
- Direction commit: on pb, if duty_i==0 and dir_i != cur_dir_i, then cur_dir_i <= dir_i. Ramp-up in the new direction starts at the next ramp_tick.
- enable_i falling: pwm_a_i/pwm_b_i are forced low on the next clock (coast). duty_i is cleared to 0 on the same clock. Re-enable ramps up from 0.
- speed or dir changed mid-period: sampled only at pb/ramp_tick. Reversing dir back before zero is reached cancels the reversal, and the ramp resumes toward speed.
- at_speed_i is registered: (duty==tgt) && (cur_dir==dir) && enable_i.
- Channels are fully independent, except for the shared cnt/ramp_cnt.

Decomposition:
- Package pwm_motor_pkg:
  - DIR_FWD/DIR_REV constants;
  - function sat_step(duty, tgt, step) returning the next duty.
- Sub-module pwm_ramp_channel, one per channel via generate:
  - inputs: pb, ramp_tick, cnt, enable, speed, dir;
  - outputs: pwm_a, pwm_b, duty, at_speed.
- The top level holds cnt, ramp_cnt, reset synchroniser and the port flattening.

Test Plan:
(Bench parameters: WIDTH=4 (MAX=15, period 15 cycles), CHANNELS=2, RAMP_STEP=4, RAMP_PERIODS=1.)
- Reset:
  - rst_n low mid-run with duty=12 → pwm_a/pwm_b low within the same cycle, duty=0.
  - After release, outputs stay 0 with enable=0.
- Soft-start:
  - ch0 enable=1, speed=12, dir=0 → duty steps 4, 8, 12 at successive pb.
  - pwm_a high 12 of 15 cycles; at_speed=1 after 3rd tick; pwm_b never high.
- Full/zero duty:
  - speed=15 → pwm_a constant high once duty=15.
  - speed=0 → ramps 15, 11, 7, 3, 0, then constant low.
- Reversal:
  - at duty=12 fwd, dir→1 → duty 8, 4, 0.
  - cur_dir flips at the pb with duty=0, then duty 4, 8, 12 on pwm_b.
  - pwm_a & pwm_b == 0 every cycle.
- Enable drop/re-enable:
  - enable=0 at duty=12 → outputs low next cycle, duty=0.
  - enable=1 → ramps from 4.
  - A 2-cycle enable pulse low also restarts the ramp from 0.
- Independence:
  - ch0 speed=8 fwd, ch1 speed=14 rev simultaneously → each reaches its own duty.
  - ch1 reversal does not perturb ch0 duty or at_speed.
